alu_share_arbiter: RTL and testbench

- Shares the single 32-bit ALU (CLA adder plus SLT result select, 3-bit ALUop) between two requesters.
- Requester 0 is the main execute path; requester 1 is the branch/compare helper.
- Captures operands, drives the ALU for a programmable settle time, registers the result, and returns it with a valid/ready handshake.
- Round-robin grant by default; fixed priority when the optional feature is compiled in.

---
 rtl/alu_share_arbiter.sv | 134 +++++++++++++
 tb/tb_alu_share_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Two-requester arbiter in front of one shared ALU: capture operands, wait ALU_LAT cycles, return result.
// Define ALU_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins); default build is round robin.
module alu_share_arbiter #(
  parameter int WIDTH   = 32,
  parameter int OPW     = 3,
  parameter int ALU_LAT = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [OPW-1:0]   req0_op,
  input  logic [WIDTH-1:0] req0_a,
  input  logic [WIDTH-1:0] req0_b,
  input  logic [OPW-1:0]   req1_op,
  input  logic [WIDTH-1:0] req1_a,
  input  logic [WIDTH-1:0] req1_b,
  output logic [OPW-1:0]   alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  output logic [1:0]       rsp_valid,
  input  logic [1:0]       rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             busy
);

  // state | meaning
  // IDLE  | no transaction; arbitrate and accept one request
  // EXEC  | ALU inputs held, settle counter running down to 0
  // DONE  | result registered, rsp_valid[gnt] waiting for rsp_ready[gnt]
  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  localparam logic [3:0] LAT_M1 = 4'(ALU_LAT - 1);

  state_t     state_q, state_d;
  logic       gnt_q, gnt_d;
  logic [3:0] cnt_q, cnt_d;
  logic       sel;
  logic       accept;
  logic       capture;
  logic       complete;
  logic [1:0] req_ready_d;

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign sel = ~req_valid[0];
`else
  logic rr_ptr_q;

  assign sel = (&req_valid) ? rr_ptr_q : req_valid[1];

  // Pointer moves only when a response completes, so it names the loser of the last transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q <= 1'b0;
    end else if (complete) begin
      rr_ptr_q <= ~gnt_q;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    capture     = 1'b0;
    complete    = 1'b0;
    req_ready_d = 2'b00;
    rsp_valid   = 2'b00;
    busy        = (state_q != IDLE);
    case (state_q)
      IDLE: begin
        if (|req_valid) begin
          req_ready_d = sel ? 2'b10 : 2'b01;
          accept      = 1'b1;
          gnt_d       = sel;
          cnt_d       = LAT_M1;
          state_d     = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == 4'd0) begin
          capture = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        rsp_valid = gnt_q ? 2'b10 : 2'b01;
        if (rsp_ready[gnt_q]) begin
          complete = 1'b1;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Gated by reset so no accept is advertised while the block is held in reset.
  assign req_ready = rst_n ? req_ready_d : 2'b00;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_op     <= '0;
      alu_a      <= '0;
      alu_b      <= '0;
      rsp_result <= '0;
    end else begin
      if (accept) begin
        alu_op <= sel ? req1_op : req0_op;
        alu_a  <= sel ? req1_a  : req0_a;
        alu_b  <= sel ? req1_b  : req0_b;
      end
      if (capture) begin
        rsp_result <= alu_result;
      end
    end
  end

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Self-checking bench: directed scenarios plus random transactions against a transaction-level model.
module tb_alu_share_arbiter;

  logic        clk;
  logic        rst_n;
  logic [1:0]  req_valid, req_ready, rsp_valid, rsp_ready;
  logic [2:0]  req0_op, req1_op, alu_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b, alu_a, alu_b, alu_result, rsp_result;
  logic        busy;

  logic [1:0]  req_valid3, req_ready3, rsp_valid3, rsp_ready3;
  logic [2:0]  req0_op3, req1_op3, alu_op3;
  logic [31:0] req0_a3, req0_b3, req1_a3, req1_b3, alu_a3, alu_b3, alu_result3, rsp_result3;
  logic        busy3;

  int n_cmp = 0;
  int n_err = 0;
  bit pref  = 1'b0;

  function automatic logic [31:0] alu_fn(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    case (op)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b100:  return {31'd0, ($signed(a) < $signed(b))};
      default: return a ^ b;
    endcase
  endfunction

  assign alu_result  = alu_fn(alu_op, alu_a, alu_b);
  assign alu_result3 = alu_fn(alu_op3, alu_a3, alu_b3);

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(1)) u_dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b), .alu_result(alu_result),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result), .busy(busy)
  );

  alu_share_arbiter #(.WIDTH(32), .OPW(3), .ALU_LAT(3)) u_dut3 (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid3), .req_ready(req_ready3),
    .req0_op(req0_op3), .req0_a(req0_a3), .req0_b(req0_b3),
    .req1_op(req1_op3), .req1_a(req1_a3), .req1_b(req1_b3),
    .alu_op(alu_op3), .alu_a(alu_a3), .alu_b(alu_b3), .alu_result(alu_result3),
    .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready3), .rsp_result(rsp_result3), .busy(busy3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // One complete transaction on the ALU_LAT=1 instance, starting and ending just after a rising edge.
  task automatic txn1(input logic [1:0] v, input logic [2:0] o0, input logic [31:0] a0, input logic [31:0] b0,
                      input logic [2:0] o1, input logic [31:0] a1, input logic [31:0] b1, input int stall);
    bit          w;
    logic [2:0]  eo;
    logic [31:0] ea, eb, er;
    logic [1:0]  oh, other;
    req_valid = v;
    req0_op = o0; req0_a = a0; req0_b = b0;
    req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = 2'b00;
    @(negedge clk);
    if (v == 2'b00) begin
      check("idle_ready", 32'(req_ready), 32'd0);
      nxt();
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      nxt();
      return;
    end
    if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      w = 1'b0;
`else
      w = pref;
`endif
    end else begin
      w = (v == 2'b10);
    end
    eo = w ? o1 : o0;
    ea = w ? a1 : a0;
    eb = w ? b1 : b0;
    er = alu_fn(eo, ea, eb);
    oh    = w ? 2'b10 : 2'b01;
    other = w ? 2'b01 : 2'b10;
    check("req_ready", 32'(req_ready), 32'(oh));
    check("busy_idle", 32'(busy), 32'd0);
    nxt();
    req_valid = 2'($urandom_range(0, 3));
    req0_a = $urandom; req0_b = $urandom; req1_a = $urandom; req1_b = $urandom;
    req0_op = 3'($urandom_range(0, 7)); req1_op = 3'($urandom_range(0, 7));
    @(negedge clk);
    check("exec_busy", 32'(busy), 32'd1);
    check("exec_rsp_valid", 32'(rsp_valid), 32'd0);
    check("exec_ready", 32'(req_ready), 32'd0);
    check("exec_alu_op", 32'(alu_op), 32'(eo));
    check("exec_alu_a", alu_a, ea);
    check("exec_alu_b", alu_b, eb);
    nxt();
    for (int s = 0; s < stall; s++) begin
      rsp_ready = ($urandom_range(0, 1) == 1) ? other : 2'b00;
      @(negedge clk);
      check("stall_rsp_valid", 32'(rsp_valid), 32'(oh));
      check("stall_result", rsp_result, er);
      check("stall_ready", 32'(req_ready), 32'd0);
      nxt();
    end
    rsp_ready = oh | (($urandom_range(0, 1) == 1) ? other : 2'b00);
    req_valid = v;
    @(negedge clk);
    check("done_rsp_valid", 32'(rsp_valid), 32'(oh));
    check("done_result", rsp_result, er);
    check("done_ready", 32'(req_ready), 32'd0);
    nxt();
    rsp_ready = 2'b00;
    req_valid = 2'b00;
    @(negedge clk);
    check("after_busy", 32'(busy), 32'd0);
    check("after_rsp_valid", 32'(rsp_valid), 32'd0);
    pref = ~w;
    nxt();
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = 2'b00; rsp_ready = 2'b00;
    req0_op = 3'd0; req0_a = 32'd0; req0_b = 32'd0;
    req1_op = 3'd0; req1_a = 32'd0; req1_b = 32'd0;
    req_valid3 = 2'b00; rsp_ready3 = 2'b00;
    req0_op3 = 3'd0; req0_a3 = 32'd0; req0_b3 = 32'd0;
    req1_op3 = 3'd0; req1_a3 = 32'd0; req1_b3 = 32'd0;
    #2;
    check("rst_alu_op", 32'(alu_op), 32'd0);
    check("rst_alu_a", alu_a, 32'd0);
    check("rst_rsp_result", rsp_result, 32'd0);
    check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    nxt();
    nxt();
    rst_n = 1'b1;
    nxt();

    // add 5+7 from requester 0, immediate rsp_ready
    txn1(2'b01, 3'b010, 32'd5, 32'd7, 3'b000, 32'd0, 32'd0, 0);
    check("add_result", rsp_result, 32'd12);

    // fresh reset so the tie-break pointer starts at requester 0
    rst_n = 1'b0; #1; rst_n = 1'b1; pref = 1'b0;
    nxt();
    txn1(2'b11, 3'b110, 32'd100, 32'd1, 3'b001, 32'hF0, 32'h0F, 0);
    txn1(2'b11, 3'b110, 32'd100, 32'd1, 3'b001, 32'hF0, 32'h0F, 1);
    txn1(2'b11, 3'b000, 32'hFF00, 32'h0FF0, 3'b100, 32'd3, 32'd2, 0);

    // signed slt from requester 1 with a 5-cycle response stall
    txn1(2'b10, 3'b000, 32'd0, 32'd0, 3'b100, 32'hFFFF_FFFF, 32'd1, 5);
    check("slt_result", rsp_result, 32'd1);

    // ALU_LAT=3: operands changed after acceptance must not reach the ALU
    req_valid3 = 2'b01; req0_op3 = 3'b110; req0_a3 = 32'd50; req0_b3 = 32'd8;
    @(negedge clk);
    check("l3_ready", 32'(req_ready3), 32'd1);
    nxt();
    req_valid3 = 2'b00; req0_a3 = 32'd999; req0_b3 = 32'd1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("l3_alu_a", alu_a3, 32'd50);
      check("l3_alu_b", alu_b3, 32'd8);
      check("l3_rsp_valid_exec", 32'(rsp_valid3), 32'd0);
      nxt();
    end
    rsp_ready3 = 2'b01;
    @(negedge clk);
    check("l3_rsp_valid", 32'(rsp_valid3), 32'd1);
    check("l3_result", rsp_result3, 32'd42);
    nxt();
    rsp_ready3 = 2'b00;
    @(negedge clk);
    check("l3_busy", 32'(busy3), 32'd0);
    nxt();

    // reset during EXEC after requester 0 won, so the pointer would favour requester 1
    txn1(2'b01, 3'b010, 32'd1, 32'd2, 3'b000, 32'd0, 32'd0, 0);
    req_valid = 2'b01; req0_op = 3'b001; req0_a = 32'hAAAA; req0_b = 32'h5555;
    nxt();
    req_valid = 2'b00;
    rst_n = 1'b0;
    #1;
    check("mid_rst_alu_op", 32'(alu_op), 32'd0);
    check("mid_rst_alu_a", alu_a, 32'd0);
    check("mid_rst_alu_b", alu_b, 32'd0);
    check("mid_rst_result", rsp_result, 32'd0);
    check("mid_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("mid_rst_ready", 32'(req_ready), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd0);
    nxt();
    rst_n = 1'b1;
    pref = 1'b0;
    rsp_ready = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
      check("post_rst_busy", 32'(busy), 32'd0);
      nxt();
    end
    rsp_ready = 2'b00;
    txn1(2'b11, 3'b010, 32'd9, 32'd9, 3'b110, 32'd9, 32'd10, 0);

    // random traffic
    for (int i = 0; i < 40; i++) begin
      logic [31:0] ra0, rb0, ra1, rb1;
      ra0 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      rb0 = $urandom;
      ra1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      rb1 = ($urandom_range(0, 1) == 1) ? $urandom : 32'($urandom_range(0, 20));
      txn1(2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)), ra0, rb0,
           3'($urandom_range(0, 7)), ra1, rb1, $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
